uart_tx_buffered: RTL

//   Transmit stage paired with the UART receiver: accepts bytes via valid/ready into a

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_fifo.sv | 65 ++++++
 rtl/uart_tx_buffered.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART transmitter and receiver: the FSM state
//   encoding, the frame data width, the idle line level and an even-parity
//   helper.
// ----------------------------------------------------------------------------
package uart_pkg;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   // Even parity: the parity bit makes the total count of ones even.
   function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
//   Synchronous show-ahead FIFO. The head entry is always visible on rd_data.
//   Writes while full and reads while empty are ignored.
//
//   clk      in   system clock
//   rstN     in   asynchronous active-low reset (pointers and count only)
//   wr_en    in   write request
//   wr_data  in   data to write
//   rd_en    in   read request (consumes the head entry)
//   rd_data  out  head entry
//   full     out  count == DEPTH
//   empty    out  count == 0
//   count    out  entries held, 0..DEPTH
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     rstN,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_wr;
   logic              do_rd;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_wr && !do_rd)      count <= count + CNT_W'(1);
         else if (do_rd && !do_wr) count <= count - CNT_W'(1);
      end
   end

   // Storage carries data only; it needs no reset.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// ----------------------------------------------------------------------------
// uart_tx_buffered
//   Buffered UART transmitter. Bytes enter a FIFO through a valid/ready
//   handshake and leave as 8N1 frames, LSB first, on a registered line.
//   Define UART_TX_PARITY_EN to insert an even parity bit (8E1 frames).
//
//   clk        in   system clock
//   rstN       in   asynchronous active-low reset
//   txData     in   byte to transmit
//   txValid    in   txData valid this cycle
//   txReady    out  FIFO not full
//   uartTx     out  serial line, idle high
//   fifoCount  out  bytes waiting in the FIFO (not counting the one on the wire)
//   busy       out  frame in progress or FIFO non-empty
// ----------------------------------------------------------------------------
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int DELAY_FRAMES = 234,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          rstN,
   input  logic [UART_DATA_BITS-1:0]     txData,
   input  logic                          txValid,
   output logic                          txReady,
   output logic                          uartTx,
   output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
   output logic                          busy
);

   localparam int CYC_W = $clog2(DELAY_FRAMES);
   localparam int BIT_W = $clog2(UART_DATA_BITS);
   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(DELAY_FRAMES - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

   tx_state_t                 state, state_nxt;
   logic [CYC_W-1:0]          cyc_cnt, cyc_nxt;
   logic [BIT_W-1:0]          bit_idx, bit_nxt;
   logic [UART_DATA_BITS-1:0] shift_reg;
   logic                      tx_line, tx_nxt;
   logic                      bit_end;
   logic                      pop;
   logic [UART_DATA_BITS-1:0] fifo_rd_data;
   logic                      fifo_full;
   logic                      fifo_empty;

   uart_tx_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (UART_DATA_BITS)
   ) u_fifo (
      .clk     (clk),
      .rstN    (rstN),
      .wr_en   (txValid),
      .wr_data (txData),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifoCount)
   );

   assign txReady = !fifo_full;
   assign busy    = (state != IDLE) || (fifoCount != '0);
   assign uartTx  = tx_line;
   assign bit_end = (cyc_cnt == CYC_LAST);

   // tx_nxt is the level for the current state; registering it delays the
   // line by one clock, which is why the start bit appears two clocks after
   // the push edge (one for the pop, one for the line register).
   always_comb begin
      state_nxt = state;
      cyc_nxt   = bit_end ? '0 : cyc_cnt + CYC_W'(1);
      bit_nxt   = bit_idx;
      tx_nxt    = UART_IDLE_LEVEL;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            cyc_nxt = '0;
            bit_nxt = '0;
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            tx_nxt = 1'b0;
            if (bit_end) state_nxt = DATA;
         end
         DATA: begin
            tx_nxt = shift_reg[bit_idx];
            if (bit_end) begin
               bit_nxt = bit_idx + BIT_W'(1);
               if (bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end
            end
         end
         PARITY: begin
            tx_nxt = even_parity(shift_reg);
            if (bit_end) state_nxt = STOP;
         end
         STOP: begin
            if (bit_end) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cyc_nxt   = '0;
            bit_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state   <= IDLE;
         cyc_cnt <= '0;
         bit_idx <= '0;
         tx_line <= UART_IDLE_LEVEL;
      end else begin
         state   <= state_nxt;
         cyc_cnt <= cyc_nxt;
         bit_idx <= bit_nxt;
         tx_line <= tx_nxt;
      end
   end

   // Frame byte, captured when it leaves the FIFO; held for the whole frame.
   always_ff @(posedge clk) begin
      if (pop) shift_reg <= fifo_rd_data;
   end

endmodule
